multi_button_pattern_detector: RTL and testbench

- Parametrised N-channel push-button front end plus sequence detector for the lab board.
- Each raw button is synchronised and debounced symmetrically, so both press and release are filtered.
- Each press is encoded as a symbol (the button index), and the block detects a programmable sequence of presses.
- Outputs: a one-cycle match pulse and a toggling match indicator for LED use. Sits between the board buttons and top-level display logic.

---
 rtl/multi_button_pattern_detector.sv | 148 ++++++++++++++
 tb/tb_multi_button_pattern_detector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_button_pattern_detector.sv
// N-channel push-button front end: two-flop synchroniser, symmetric debounce,
// press encoding and a programmable press-sequence detector with idle timeout.
module multi_button_pattern_detector #(
    parameter int                               NUM_BUTTONS     = 2,
    parameter int                               SYM_W           = 1,
    parameter int                               DEBOUNCE_CYCLES = 65535,
    parameter int                               PATTERN_LEN     = 4,
    parameter logic [PATTERN_LEN*SYM_W-1:0]     PATTERN         = 4'b1101,
    parameter bit                               OVERLAP         = 1'b1,
    parameter int                               TIMEOUT_CYCLES  = 0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_BUTTONS-1:0]              raw_button,
    output logic [NUM_BUTTONS-1:0]              clean_button,
    output logic [NUM_BUTTONS-1:0]              press_pulse,
    output logic                                match,
    output logic                                match_toggle,
    output logic                                error,
    output logic [$clog2(PATTERN_LEN+1)-1:0]    hist_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HC_W   = $clog2(PATTERN_LEN + 1);
    localparam int HW     = PATTERN_LEN * SYM_W;
    localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HC_W-1:0]   HC_FULL  = HC_W'(PATTERN_LEN);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [NUM_BUTTONS-1:0]            sync1_q, sync1_d;
    logic [NUM_BUTTONS-1:0]            sync_q, sync_d;
    logic [NUM_BUTTONS-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [NUM_BUTTONS-1:0]            clean_q, clean_d;
    logic [NUM_BUTTONS-1:0]            press_q, press_d;
    logic                              match_q, match_d;
    logic                              toggle_q, toggle_d;
    logic                              error_q, error_d;
    logic [HW-1:0]                     hist_q, hist_d;
    logic [HC_W-1:0]                   hcount_q, hcount_d;
    logic [IDLE_W-1:0]                 idle_q, idle_d;

    logic [SYM_W-1:0]                  sym_s;
    logic                              single_s;
    logic                              multi_s;
    logic                              timeout_s;
    logic                              clear_s;
    logic [IDLE_W-1:0]                 idle_inc_s;
    logic [HC_W-1:0]                   hc_base_s;
    logic [HC_W-1:0]                   hc_inc_s;

    // State register for the whole block
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync_q   <= '0;
            db_cnt_q <= '0;
            clean_q  <= '0;
            press_q  <= '0;
            match_q  <= 1'b0;
            toggle_q <= 1'b0;
            error_q  <= 1'b0;
            hist_q   <= '0;
            hcount_q <= '0;
            idle_q   <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync_q   <= sync_d;
            db_cnt_q <= db_cnt_d;
            clean_q  <= clean_d;
            press_q  <= press_d;
            match_q  <= match_d;
            toggle_q <= toggle_d;
            error_q  <= error_d;
            hist_q   <= hist_d;
            hcount_q <= hcount_d;
            idle_q   <= idle_d;
        end
    end

    // Next-state: debounce, press encoding, history, match and timeout
    always_comb begin
        sync1_d  = raw_button;
        sync_d   = sync1_q;
        clean_d  = clean_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (sync_q[i] == clean_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i] = '0;
                clean_d[i]  = sync_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
        press_d = clean_d & ~clean_q;

        sym_s = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            sym_s = sym_s | (press_q[i] ? SYM_W'(i) : {SYM_W{1'b0}});
        end
        single_s   = (press_q != '0) && ((press_q & (press_q - NUM_BUTTONS'(1))) == '0);
        multi_s    = (press_q != '0) && !single_s;
        idle_inc_s = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1);
        timeout_s  = (TIMEOUT_CYCLES > 0) && (idle_q == IDLE_MAX) && (hcount_q != '0);
        clear_s    = (OVERLAP == 1'b0) && match_q;
        // A press coinciding with the timeout starts a fresh history
        hc_base_s  = timeout_s ? '0 : hcount_q;
        hc_inc_s   = (hc_base_s == HC_FULL) ? HC_FULL : hc_base_s + HC_W'(1);

        hist_d   = hist_q;
        hcount_d = hcount_q;
        idle_d   = idle_inc_s;
        match_d  = 1'b0;
        error_d  = 1'b0;
        toggle_d = toggle_q;
        if (single_s) begin
            hist_d   = (hist_q << SYM_W) | HW'(sym_s);
            hcount_d = clear_s ? '0 : hc_inc_s;
            idle_d   = '0;
            if ((hcount_d == HC_FULL) && (hist_d == PATTERN)) begin
                match_d  = 1'b1;
                toggle_d = ~toggle_q;
            end else begin
                match_d  = 1'b0;
                toggle_d = toggle_q;
            end
        end else if (multi_s) begin
            hist_d   = '0;
            hcount_d = '0;
            error_d  = 1'b1;
        end else if (timeout_s || clear_s) begin
            hcount_d = '0;
        end else begin
            hcount_d = hcount_q;
        end
    end

    assign clean_button = clean_q;
    assign press_pulse  = press_q;
    assign match        = match_q;
    assign match_toggle = toggle_q;
    assign error        = error_q;
    assign hist_count   = hcount_q;

endmodule

// File: tb/tb_multi_button_pattern_detector.sv
// Scoreboard bench: two detectors (overlap+timeout, no-overlap/no-timeout) share
// one button stimulus; expected output events are queued and checked by a monitor.
module tb_multi_button_pattern_detector;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] raw   = 2'b00;

    logic [1:0] cl_a, pp_a, cl_b, pp_b;
    logic       m_a, t_a, e_a, m_b, t_b, e_b;
    logic [2:0] hc_a, hc_b;

    multi_button_pattern_detector #(
        .NUM_BUTTONS(2), .SYM_W(1), .DEBOUNCE_CYCLES(D), .PATTERN_LEN(4),
        .PATTERN(4'b1101), .OVERLAP(1'b1), .TIMEOUT_CYCLES(20)
    ) dut_a (
        .clock(clock), .reset(reset), .raw_button(raw),
        .clean_button(cl_a), .press_pulse(pp_a), .match(m_a),
        .match_toggle(t_a), .error(e_a), .hist_count(hc_a)
    );

    multi_button_pattern_detector #(
        .NUM_BUTTONS(2), .SYM_W(1), .DEBOUNCE_CYCLES(D), .PATTERN_LEN(4),
        .PATTERN(4'b1101), .OVERLAP(1'b0), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .clock(clock), .reset(reset), .raw_button(raw),
        .clean_button(cl_b), .press_pulse(pp_b), .match(m_b),
        .match_toggle(t_b), .error(e_b), .hist_count(hc_b)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] pp;
        logic [1:0] cl;
        logic       m;
        logic       t;
        logic       e;
        logic [2:0] hc;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    int  errors = 0;
    int  checks = 0;

    // reference model state, index 0 = dut_a, 1 = dut_b
    int         m_cnt[2];
    logic [3:0] m_hist[2];
    int         m_last[2];
    logic       m_tog[2];
    bit         m_ovl[2] = '{1'b1, 1'b0};
    bit         m_to[2]  = '{1'b1, 1'b0};

    function automatic int eff_cnt(input int m, input int now);
        if (m_to[m] && m_cnt[m] != 0 && (now - m_last[m]) >= 22) return 0;
        return m_cnt[m];
    endfunction

    task automatic push(input int m, input ev_t e);
        if (m == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_cnt[m] = 0; m_hist[m] = 4'b0000; m_last[m] = 0; m_tog[m] = 1'b0;
        end
    endtask

    // Queue the events a debounced press of 'mask' visible in cycle p must cause
    task automatic model_press(input logic [1:0] mask, input int p);
        for (int m = 0; m < 2; m++) begin
            int  c;
            ev_t e;
            c = eff_cnt(m, p);
            e.cyc = p; e.pp = mask; e.cl = mask; e.m = 1'b0;
            e.t = m_tog[m]; e.e = 1'b0; e.hc = 3'(c);
            push(m, e);
            if (mask == 2'b01 || mask == 2'b10) begin
                m_hist[m] = {m_hist[m][2:0], mask[1]};
                c = (c == 4) ? 4 : c + 1;
                m_last[m] = p;
                if (c == 4 && m_hist[m] == 4'b1101) begin
                    m_tog[m] = ~m_tog[m];
                    e.cyc = p + 1; e.pp = 2'b00; e.m = 1'b1; e.t = m_tog[m]; e.hc = 3'd4;
                    push(m, e);
                    if (!m_ovl[m]) c = 0;
                end
                m_cnt[m] = c;
            end else begin
                e.cyc = p + 1; e.pp = 2'b00; e.e = 1'b1; e.hc = 3'd0;
                push(m, e);
                m_cnt[m] = 0;
                m_hist[m] = 4'b0000;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic [1:0] pp, input logic [1:0] cl,
                       input logic m, input logic t, input logic e, input logic [2:0] hc);
        ev_t x;
        checks++;
        if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_event dut%0d cyc=%0d pp=%b match=%b err=%b hc=%0d",
                     id, cyc, pp, m, e, hc);
        end else begin
            if (id == 0) x = q_a.pop_front();
            else         x = q_b.pop_front();
            if (x.cyc != cyc || x.pp != pp || x.cl != cl || x.m != m ||
                x.t != t || x.e != e || x.hc != hc) begin
                errors++;
                $display("FAIL event dut%0d: got cyc=%0d pp=%b cl=%b m=%b t=%b e=%b hc=%0d, expected cyc=%0d pp=%b cl=%b m=%b t=%b e=%b hc=%0d",
                         id, cyc, pp, cl, m, t, e, hc, x.cyc, x.pp, x.cl, x.m, x.t, x.e, x.hc);
            end
        end
    endtask

    // Monitor: every press/match/error cycle must match the head of the queue
    always @(negedge clock) begin
        if (!reset) begin
            if (pp_a != 2'b00 || m_a || e_a) mon(0, pp_a, cl_a, m_a, t_a, e_a, hc_a);
            if (pp_b != 2'b00 || m_b || e_b) mon(1, pp_b, cl_b, m_b, t_b, e_b, hc_b);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [1:0] mask);
        raw = mask;
        model_press(mask, cyc + 2 + D);
        step(8);
        raw = 2'b00;
        step(8);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_clean_a"}, int'(cl_a), 0); chk({tag, "_pp_a"}, int'(pp_a), 0);
        chk({tag, "_match_a"}, int'(m_a), 0);  chk({tag, "_tog_a"}, int'(t_a), 0);
        chk({tag, "_err_a"}, int'(e_a), 0);    chk({tag, "_hc_a"}, int'(hc_a), 0);
        chk({tag, "_clean_b"}, int'(cl_b), 0); chk({tag, "_pp_b"}, int'(pp_b), 0);
        chk({tag, "_match_b"}, int'(m_b), 0);  chk({tag, "_tog_b"}, int'(t_b), 0);
        chk({tag, "_err_b"}, int'(e_b), 0);    chk({tag, "_hc_b"}, int'(hc_b), 0);
    endtask

    initial begin
        model_reset();
        step(3);
        chk_zero("reset");
        reset = 1'b0;
        step(2);

        // bounce 1,0,1,0 then hold: clean rises 6 cycles after the last edge
        raw = 2'b10; step(1);
        raw = 2'b00; step(1);
        raw = 2'b10; step(1);
        raw = 2'b00; step(1);
        raw = 2'b10;
        model_press(2'b10, cyc + 6);
        step(8);
        raw = 2'b00;
        step(8);

        // 1,1,0,1,1,0,1: overlapping matches on dut_a, one match on dut_b
        step(30);
        press(2'b10); press(2'b10); press(2'b01); press(2'b10);
        chk("hc_after_match_a", int'(hc_a), eff_cnt(0, cyc));
        chk("hc_after_match_b", int'(hc_b), eff_cnt(1, cyc));
        press(2'b10); press(2'b01); press(2'b10);

        // simultaneous press -> error, then a clean match
        step(30);
        press(2'b11);
        chk("hc_after_error_a", int'(hc_a), 0);
        press(2'b10); press(2'b10); press(2'b01); press(2'b10);

        // timeout clears dut_a history; dut_b keeps it
        step(30);
        press(2'b10); press(2'b10); press(2'b01);
        step(25);
        chk("hc_timeout_a", int'(hc_a), eff_cnt(0, cyc));
        chk("hc_timeout_b", int'(hc_b), eff_cnt(1, cyc));
        press(2'b10);
        chk("hc_after_timeout_a", int'(hc_a), eff_cnt(0, cyc));

        // reset mid-sequence and mid-debounce with the button held
        step(30);
        press(2'b10); press(2'b10); press(2'b01);
        chk("hc_pre_reset_a", int'(hc_a), eff_cnt(0, cyc));
        chk("hc_pre_reset_b", int'(hc_b), eff_cnt(1, cyc));
        raw = 2'b10;
        step(3);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("midrst");
        model_reset();
        step(2);
        reset = 1'b0;
        model_press(2'b10, cyc + 2 + D);
        step(8);
        raw = 2'b00;
        step(10);

        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
